// File: rtl/inst_rom_ctrl.sv
// inst_rom_ctrl: 1-cycle instruction fetch responder with byte-serial big-endian program loader.
// Optional ROM_BOUND_CHK_EN adds err_o for misaligned or out-of-range fetch addresses.
`default_nettype none

module inst_rom_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  input  logic              load_en_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic [ADDR_W:0]   load_cnt_o
`ifdef ROM_BOUND_CHK_EN
  ,
  output logic              err_o
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4,
    WR   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic [ADDR_W-1:0] rd_idx;
  logic              accept;
  logic              wr_en;

  assign rd_idx = addr_i[ADDR_W+1:2];
  assign accept = load_valid_i & load_ready_o;
  // A reset arriving in WR aborts the session, so the pending write is dropped too.
  assign wr_en  = rst && (state == WR);

`ifdef ROM_BOUND_CHK_EN
  logic bad_addr;
  assign bad_addr = (addr_i[1:0] != 2'b00) || (addr_i[31:ADDR_W+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
`endif

  // Array has no reset: contents survive rst so a loaded program is retained.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      word         <= '0;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      load_ready_o <= 1'b0;
      load_done_o  <= 1'b0;
      load_cnt_o   <= '0;
`ifdef ROM_BOUND_CHK_EN
      err_o        <= 1'b0;
`endif
    end else begin
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      load_done_o  <= 1'b0;
`ifdef ROM_BOUND_CHK_EN
      err_o        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (load_en_i) begin
            state        <= B0;
            ptr          <= '0;
            load_cnt_o   <= '0;
            load_ready_o <= 1'b1;
          end else if (ce_i) begin
            inst_valid_o <= 1'b1;
`ifdef ROM_BOUND_CHK_EN
            if (bad_addr) begin
              err_o <= 1'b1;
            end else begin
              inst_o <= mem[rd_idx];
            end
`else
            inst_o <= mem[rd_idx];
`endif
          end
        end

        B0, B1, B2, B3: begin
          if (!load_en_i) begin
            state        <= IDLE;
            load_ready_o <= 1'b0;
            load_done_o  <= 1'b1;
          end else if (accept) begin
            // Shifting in MSB-first places byte k at bits [31-8k -: 8] after four bytes.
            word <= {word[23:0], load_byte_i};
            case (state)
              B0:      state <= B1;
              B1:      state <= B2;
              B2:      state <= B3;
              default: begin
                state        <= WR;
                load_ready_o <= 1'b0;
              end
            endcase
          end
        end

        WR: begin
          ptr <= ptr + 1'b1;
          if (load_cnt_o != CNT_MAX) begin
            load_cnt_o <= load_cnt_o + 1'b1;
          end
          if (!load_en_i) begin
            state        <= IDLE;
            load_ready_o <= 1'b0;
            load_done_o  <= 1'b1;
          end else begin
            state        <= B0;
            load_ready_o <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          load_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/inst_rom_ctrl.md
Name: inst_rom_ctrl

Overview:
- Instruction-memory responder for the CPU fetch port. It answers the core's instruction-ROM chip-enable and byte-address with the 32-bit instruction word.
- Also owns a byte-serial program-load port. A loader streams a big-endian program image into the array before or between runs.
- Sits beside the CPU top in the SoC wrapper: the core's ROM enable/address drive ce_i/addr_i, and inst_o drives the core's ROM data input.

Parameters:
ADDR_W, 10, word-address width; array depth = 2**ADDR_W words (default 1024 words = 4 KiB).

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge).
ce_i  in  1  fetch enable from core.
addr_i  in  32  fetch byte address from core.
inst_o  out  32  instruction word returned to core.
inst_valid_o  out  1  inst_o carries a fetched word this cycle.
load_en_i  in  1  load mode request (level).
load_byte_i  in  8  program byte.
load_valid_i  in  1  load_byte_i valid.
load_ready_o  out  1  controller accepts a byte this cycle.
load_done_o  out  1  one-cycle pulse when load mode ends.
load_cnt_o  out  ADDR_W+1  words written in the current or last load session.

Behaviour:
- Reset (rst=0 at an edge): inst_o=0, inst_valid_o=0, load_ready_o=0, load_done_o=0, load_cnt_o=0. FSM goes to IDLE, load pointer=0, byte assembly register=0. Array contents are not cleared.
- Fetch:
  - Word index = addr_i[ADDR_W+1:2]; addr_i[1:0] and addr_i[31:ADDR_W+2] are ignored, so addresses alias modulo depth.
  - Latency is 1 cycle, registered: ce_i=1 in cycle N gives mem[index] on inst_o with inst_valid_o=1 in cycle N+1.
  - ce_i=0 in cycle N gives inst_o=0 and inst_valid_o=0 in N+1.
  - A fetch is serviced only in IDLE. In any load state, inst_o=0 and inst_valid_o=0 regardless of ce_i.
- Load FSM states: IDLE, B0, B1, B2, B3, WR.
  - IDLE -> B0 when load_en_i=1. On this transition: pointer=0, load_cnt_o=0.
  - Bk (k=0..3): load_ready_o=1. A byte is accepted when load_valid_i & load_ready_o.
  - Accepted bytes fill the word most-significant first: B0 -> bits[31:24], B1 -> [23:16], B2 -> [15:8], B3 -> [7:0].
  - Bk advances to Bk+1 on acceptance; B3 advances to WR. With no acceptance, the FSM holds.
  - WR: load_ready_o=0. The assembled word is written to mem[pointer]; pointer increments and wraps at 2**ADDR_W; load_cnt_o increments. The FSM then goes to B0.
  - load_cnt_o saturates at 2**ADDR_W.
- Load exit: load_en_i=0 in any of B0..B3 or WR -> IDLE next cycle, with load_done_o=1 for that one cycle.
  - If load_en_i falls while in WR, that word's write still completes (counted).
  - Partial words in B1..B3 are discarded; no write occurs.
- Simultaneous events:
  - load_en_i=1 in IDLE alongside ce_i=1: load wins and no fetch response is produced.
  - rst=0 mid-load: the FSM aborts to IDLE and no load_done_o pulse is generated.
- Array is single-port, one write and one read per cycle at most. Because reads occur only in IDLE and writes only in WR, there is no read/write collision.

Optional Feature:
ROM_BOUND_CHK_EN
- Defined: adds output port err_o (1 bit, reset 0).
  - A fetch with ce_i=1 and either addr_i[1:0]!=0 or addr_i[31:ADDR_W+2]!=0 returns inst_o=0, inst_valid_o=1 and err_o=1 in the response cycle.
  - err_o=0 otherwise.
- Undefined: no err_o port. Those addresses alias as described under Fetch.

Test Plan:
1. Reset then load: rst=0 for 2 cycles, then load_en_i=1 and stream bytes 34 01 00 01, 34 02 00 02 with no stalls, then load_en_i=0 -> load_cnt_o=2, a single load_done_o pulse, mem[0]=0x34010001, mem[1]=0x34020002.
2. Fetch after load: ce_i=1 with addr_i=0x0, 0x4, 0x8 on consecutive cycles -> inst_o=0x34010001, 0x34020002, mem[2] one cycle later each, inst_valid_o=1 throughout. With ce_i=0 -> inst_o=0 and inst_valid_o=0 the next cycle.
3. Handshake stalls: toggle load_valid_i 1/0 each cycle; hold load_valid_i through WR -> no byte is taken while load_ready_o=0, and the word assembles correctly in order.
4. Abort mid-word: load_en_i=0 after 2 bytes of word 3 -> mem[2] unchanged, load_cnt_o=2, FSM in IDLE, fetch from 0x8 returns the old content.
5. Wrap/alias (ADDR_W=2):
   - Load 5 words -> the 5th word lands in mem[0] and load_cnt_o=4 (saturated).
   - Fetch at addr_i=0x10 -> returns mem[0].
   - With ROM_BOUND_CHK_EN defined, the same fetch -> inst_o=0, err_o=1.
6. Reset mid-load: rst=0 while in B2 -> all outputs at reset values next cycle, no load_done_o pulse, and previously written words are retained.
